// File: rtl/if_stage_if.sv
// Fetch-stage bundle: instruction-memory request/response, pipeline control
// inputs, and the IF/ID register outputs.
interface if_stage_if;
  logic        i_readM;
  logic [15:0] i_address;
  logic [15:0] i_data;
  logic        i_ready;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt;
  logic [15:0] IF_ID_inst;
  logic [15:0] IF_ID_pc1;
  logic        IF_ID_valid;
  logic [15:0] num_fetched;

  modport master (
    output i_readM, i_address, IF_ID_inst, IF_ID_pc1, IF_ID_valid, num_fetched,
    input  i_data, i_ready, stall, flush, redirect_valid, redirect_pc, halt
  );

  modport slave (
    input  i_readM, i_address, IF_ID_inst, IF_ID_pc1, IF_ID_valid, num_fetched,
    output i_data, i_ready, stall, flush, redirect_valid, redirect_pc, halt
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch: PC, memory request and IF/ID register; one edge from accept to IF_ID_valid.
// Memory wait holds PC and inserts bubbles; stall freezes IF/ID and PC while the word is re-requested.
module if_stage (
  input  logic       clk,
  input  logic       reset_n,
  if_stage_if.master bus
);

  typedef enum logic [1:0] {
    BOOT   = 2'b00,
    FETCH  = 2'b01,
    HALTED = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] inst_q, inst_d;
  logic [15:0] pc1_q, pc1_d;
  logic        valid_q, valid_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] pc_inc;

  assign pc_inc = pc_q + 16'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BOOT;
      pc_q    <= 16'h0000;
      inst_q  <= 16'h0000;
      pc1_q   <= 16'h0000;
      valid_q <= 1'b0;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pc1_q   <= pc1_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    pc1_d   = pc1_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        // Ordering below encodes halt > redirect > flush > stall > accept/wait.
        if (bus.halt) begin
          state_d = HALTED;
          valid_d = 1'b0;
        end else if (bus.redirect_valid) begin
          pc_d    = bus.redirect_pc;
          valid_d = 1'b0;
          inst_d  = 16'h0000;
        end else if (bus.flush) begin
          valid_d = 1'b0;
          inst_d  = 16'h0000;
        end else if (bus.stall) begin
          // Hold everything; the returned word, if any, is dropped.
        end else if (bus.i_ready) begin
          inst_d  = bus.i_data;
          pc1_d   = pc_inc;
          valid_d = 1'b1;
          pc_d    = pc_inc;
          cnt_d   = cnt_q + 16'd1;
        end else begin
          valid_d = 1'b0;
          inst_d  = 16'h0000;
        end
      end
      HALTED: begin
        // Only reset leaves this state.
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign bus.i_readM     = (state_q == FETCH);
  assign bus.i_address   = pc_q;
  assign bus.IF_ID_inst  = inst_q;
  assign bus.IF_ID_pc1   = pc1_q;
  assign bus.IF_ID_valid = valid_q;
  assign bus.num_fetched = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: cycle table with hand-derived expectations plus a queue of accepted words.
module tb_if_stage;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  if_stage_if bus ();

  if_stage dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Instruction memory: word k holds 0x4000+k, except word 4 which holds 0xF01C.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] w;
    w = 16'h4000 + a;
    if (a == 16'h0004) w = 16'hF01C;
    return w;
  endfunction

  assign bus.i_data = mem_word(bus.i_address);

  typedef enum logic [1:0] {K_ZERO, K_ACC, K_HOLD, K_ANY} kind_e;

  typedef struct {
    logic        rdy;
    logic        stall;
    logic        flush;
    logic        redir;
    logic [15:0] rpc;
    logic        halt;
    logic        exp_rd;
    logic [15:0] exp_addr;
    logic        exp_vld;
    logic [15:0] exp_nf;
    kind_e       kind;
  } vec_t;

  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] pc1;
  } sb_t;

  int   n_chk = 0;
  int   n_err = 0;
  sb_t  sb[$];
  sb_t  last;
  vec_t tbl[23];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=0x%04h required=0x%04h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rdy, input logic stall, input logic flush,
                              input logic redir, input logic [15:0] rpc, input logic halt,
                              input logic exp_rd, input logic [15:0] exp_addr,
                              input logic exp_vld, input logic [15:0] exp_nf, input kind_e kind);
    vec_t v;
    v.rdy = rdy; v.stall = stall; v.flush = flush; v.redir = redir; v.rpc = rpc;
    v.halt = halt; v.exp_rd = exp_rd; v.exp_addr = exp_addr; v.exp_vld = exp_vld;
    v.exp_nf = exp_nf; v.kind = kind;
    return v;
  endfunction

  task automatic drive(input logic rdy, input logic stall, input logic flush,
                       input logic redir, input logic [15:0] rpc, input logic halt);
    bus.i_ready        = rdy;
    bus.stall          = stall;
    bus.flush          = flush;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.halt           = halt;
  endtask

  // Compare the IF/ID register against the oldest expected accepted word.
  task automatic pop_check(input string nm);
    n_chk++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s_sb actual=empty required=entry", nm);
    end else begin
      last = sb.pop_front();
      chk({nm, "_inst"}, bus.IF_ID_inst, last.inst);
      chk({nm, "_pc1"}, bus.IF_ID_pc1, last.pc1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] cur_addr;
    string nm;

    tbl[0]  = mk(1,0,0,0,16'h0000,0, 1,16'h0000,0,16'd0, K_ZERO);
    tbl[1]  = mk(1,0,0,0,16'h0000,0, 1,16'h0001,1,16'd1, K_ACC);
    tbl[2]  = mk(1,0,0,0,16'h0000,0, 1,16'h0002,1,16'd2, K_ACC);
    tbl[3]  = mk(1,0,0,0,16'h0000,0, 1,16'h0003,1,16'd3, K_ACC);
    tbl[4]  = mk(0,0,0,0,16'h0000,0, 1,16'h0003,0,16'd3, K_ZERO);
    tbl[5]  = mk(0,0,0,0,16'h0000,0, 1,16'h0003,0,16'd3, K_ZERO);
    tbl[6]  = mk(0,0,0,0,16'h0000,0, 1,16'h0003,0,16'd3, K_ZERO);
    tbl[7]  = mk(1,0,0,0,16'h0000,0, 1,16'h0004,1,16'd4, K_ACC);
    tbl[8]  = mk(1,0,0,0,16'h0000,0, 1,16'h0005,1,16'd5, K_ACC);
    tbl[9]  = mk(1,1,0,0,16'h0000,0, 1,16'h0005,1,16'd5, K_HOLD);
    tbl[10] = mk(1,1,0,0,16'h0000,0, 1,16'h0005,1,16'd5, K_HOLD);
    tbl[11] = mk(1,0,0,0,16'h0000,0, 1,16'h0006,1,16'd6, K_ACC);
    tbl[12] = mk(1,1,0,1,16'h0040,0, 1,16'h0040,0,16'd6, K_ZERO);
    tbl[13] = mk(1,0,0,0,16'h0000,0, 1,16'h0041,1,16'd7, K_ACC);
    tbl[14] = mk(1,1,1,0,16'h0000,0, 1,16'h0041,0,16'd7, K_ZERO);
    tbl[15] = mk(1,0,0,0,16'h0000,0, 1,16'h0042,1,16'd8, K_ACC);
    tbl[16] = mk(0,1,0,0,16'h0000,0, 1,16'h0042,1,16'd8, K_HOLD);
    tbl[17] = mk(1,0,1,1,16'h0010,0, 1,16'h0010,0,16'd8, K_ZERO);
    tbl[18] = mk(1,0,0,0,16'h0000,0, 1,16'h0011,1,16'd9, K_ACC);
    tbl[19] = mk(0,0,0,1,16'hFFFF,0, 1,16'hFFFF,0,16'd9, K_ZERO);
    tbl[20] = mk(1,0,0,0,16'h0000,0, 1,16'h0000,1,16'd10, K_ACC);
    tbl[21] = mk(1,0,0,0,16'h0000,0, 1,16'h0001,1,16'd11, K_ACC);
    tbl[22] = mk(1,0,0,1,16'h0080,1, 0,16'h0001,0,16'd11, K_ANY);

    reset_n = 1'b0;
    drive(0, 0, 0, 0, 16'h0000, 0);
    last = '0;
    repeat (2) @(negedge clk);
    chk("rst_readM", {15'd0, bus.i_readM}, 16'd0);
    chk("rst_addr", bus.i_address, 16'h0000);
    chk("rst_inst", bus.IF_ID_inst, 16'h0000);
    chk("rst_pc1", bus.IF_ID_pc1, 16'h0000);
    chk("rst_valid", {15'd0, bus.IF_ID_valid}, 16'd0);
    chk("rst_nf", bus.num_fetched, 16'd0);

    reset_n = 1'b1;
    #1;
    chk("boot_readM", {15'd0, bus.i_readM}, 16'd0);

    cur_addr = 16'h0000;
    for (int r = 0; r < 23; r++) begin
      drive(tbl[r].rdy, tbl[r].stall, tbl[r].flush, tbl[r].redir, tbl[r].rpc, tbl[r].halt);
      if (tbl[r].kind == K_ACC)
        sb.push_back({mem_word(cur_addr), cur_addr + 16'd1});
      @(negedge clk);
      nm = $sformatf("row%0d", r);
      chk({nm, "_readM"}, {15'd0, bus.i_readM}, {15'd0, tbl[r].exp_rd});
      chk({nm, "_addr"}, bus.i_address, tbl[r].exp_addr);
      chk({nm, "_valid"}, {15'd0, bus.IF_ID_valid}, {15'd0, tbl[r].exp_vld});
      chk({nm, "_nf"}, bus.num_fetched, tbl[r].exp_nf);
      case (tbl[r].kind)
        K_ACC:  pop_check(nm);
        K_HOLD: begin
          chk({nm, "_hold_inst"}, bus.IF_ID_inst, last.inst);
          chk({nm, "_hold_pc1"}, bus.IF_ID_pc1, last.pc1);
        end
        K_ZERO: chk({nm, "_zero_inst"}, bus.IF_ID_inst, 16'h0000);
        default: ;
      endcase
      cur_addr = tbl[r].exp_addr;
    end

    // HALTED ignores every input.
    for (int c = 0; c < 12; c++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
      @(negedge clk);
      nm = $sformatf("halt%0d", c);
      chk({nm, "_readM"}, {15'd0, bus.i_readM}, 16'd0);
      chk({nm, "_addr"}, bus.i_address, 16'h0001);
      chk({nm, "_valid"}, {15'd0, bus.IF_ID_valid}, 16'd0);
      chk({nm, "_nf"}, bus.num_fetched, 16'd11);
    end

    // Reset pulse out of HALTED, asserted away from any edge.
    drive(1, 0, 0, 0, 16'h0000, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("hrst_readM", {15'd0, bus.i_readM}, 16'd0);
    chk("hrst_addr", bus.i_address, 16'h0000);
    chk("hrst_nf", bus.num_fetched, 16'd0);
    chk("hrst_pc1", bus.IF_ID_pc1, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("hboot_readM", {15'd0, bus.i_readM}, 16'd0);
    @(negedge clk);
    chk("hfetch_readM", {15'd0, bus.i_readM}, 16'd1);
    chk("hfetch_addr", bus.i_address, 16'h0000);
    chk("hfetch_valid", {15'd0, bus.IF_ID_valid}, 16'd0);
    sb.push_back({mem_word(16'h0000), 16'h0001});
    @(negedge clk);
    chk("hacc_valid", {15'd0, bus.IF_ID_valid}, 16'd1);
    chk("hacc_nf", bus.num_fetched, 16'd1);
    pop_check("hacc");

    // Reset while a request is outstanding; the late i_ready lands in BOOT.
    drive(0, 0, 0, 0, 16'h0000, 0);
    @(negedge clk);
    chk("mid_readM", {15'd0, bus.i_readM}, 16'd1);
    chk("mid_addr", bus.i_address, 16'h0001);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_readM", {15'd0, bus.i_readM}, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    bus.i_ready = 1'b1;
    @(negedge clk);
    chk("late_valid", {15'd0, bus.IF_ID_valid}, 16'd0);
    chk("late_nf", bus.num_fetched, 16'd0);
    chk("late_addr", bus.i_address, 16'h0000);
    chk("late_readM", {15'd0, bus.i_readM}, 16'd1);
    sb.push_back({mem_word(16'h0000), 16'h0001});
    @(negedge clk);
    chk("racc_valid", {15'd0, bus.IF_ID_valid}, 16'd1);
    chk("racc_nf", bus.num_fetched, 16'd1);
    pop_check("racc");

    n_chk++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain actual=%0d required=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
